// File: rtl/enemy_formation.sv
// Enemy formation controller: alive bitmap, classic march with edge descent,
// sequential bullet-hit scanner (one kill per shot) and registered pixel hit test.
module enemy_formation #(
   parameter int unsigned CORDW             = 10,
   parameter int unsigned ROWS_P            = 3,
   parameter int unsigned COLS_P            = 8,
   parameter int unsigned ENEMY_W_P         = 24,
   parameter int unsigned ENEMY_H_P         = 16,
   parameter int unsigned GAP_X_P           = 8,
   parameter int unsigned GAP_Y_P           = 8,
   parameter int unsigned LEFT_START_P      = 40,
   parameter int unsigned TOP_START_P       = 40,
   parameter int unsigned STEP_X_P          = 2,
   parameter int unsigned STEP_Y_P          = 8,
   parameter int unsigned FRAMES_PER_STEP_P = 4,
   parameter int unsigned LEFT_BOUND_P      = 0,
   parameter int unsigned RIGHT_BOUND_P     = 639,
   parameter int unsigned LAND_Y_P          = 429
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_async_unsafe_i,
   input  logic                                 start_i,
   input  logic                                 frame_i,
   input  logic [CORDW-1:0]                     x_i,
   input  logic [CORDW-1:0]                     y_i,
   input  logic                                 bullet_valid_i,
   input  logic [CORDW-1:0]                     bullet_left_i,
   input  logic [CORDW-1:0]                     bullet_right_i,
   input  logic [CORDW-1:0]                     bullet_top_i,
   input  logic [CORDW-1:0]                     bullet_bot_i,
   output logic                                 hit_o,
   output logic [$clog2(ROWS_P)-1:0]            hit_row_o,
   output logic [$clog2(COLS_P)-1:0]            hit_col_o,
   output logic [$clog2(ROWS_P*COLS_P+1)-1:0]   alive_count_o,
   output logic                                 pixel_on_o,
   output logic                                 landed_o,
   output logic                                 cleared_o,
   output logic [2:0]                           state_o
);

   localparam int unsigned NCELL   = ROWS_P * COLS_P;
   localparam int unsigned PITCH_X = ENEMY_W_P + GAP_X_P;
   localparam int unsigned PITCH_Y = ENEMY_H_P + GAP_Y_P;
   localparam int unsigned FORM_W  = COLS_P * ENEMY_W_P + (COLS_P - 1) * GAP_X_P;
   localparam int unsigned FORM_H  = ROWS_P * ENEMY_H_P + (ROWS_P - 1) * GAP_Y_P;
   // Two spare bits so edge/landing sums cannot wrap.
   localparam int unsigned AW      = CORDW + 2;
   localparam int unsigned RLW     = $clog2(ROWS_P);
   localparam int unsigned CLW     = $clog2(COLS_P);
   localparam int unsigned IW      = $clog2(NCELL);
   localparam int unsigned CW      = $clog2(NCELL + 1);
   localparam int unsigned FCW     = (FRAMES_PER_STEP_P > 1) ? $clog2(FRAMES_PER_STEP_P) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] MARCH   = 3'd1;
   localparam logic [2:0] LANDED  = 3'd2;
   localparam logic [2:0] CLEARED = 3'd3;

   logic [1:0]       sync_q;
   logic             rst_n;
   logic [2:0]       state_q, state_d;
   logic [CORDW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic             dir_left_q, dir_left_d;
   logic [NCELL-1:0] alive_q, alive_d;
   logic [FCW-1:0]   fcnt_q, fcnt_d;
   logic             lock_q, lock_d;
   logic [RLW-1:0]   scan_row_q, scan_row_d;
   logic [CLW-1:0]   scan_col_q, scan_col_d;
   logic             hit_q, hit_d;
   logic [RLW-1:0]   hit_row_q, hit_row_d;
   logic [CLW-1:0]   hit_col_q, hit_col_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pixel_q, pixel_d;

   logic [IW-1:0]    scan_idx;
   logic [AW-1:0]    cell_l, cell_r, cell_t, cell_b;
   logic             overlap, kill, tick, at_edge, land, clear;
   logic [CORDW-1:0] oy_desc;

   // Reset synchroniser: assertion is immediate, release follows two clock edges.
   always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
      if (!reset_n_async_unsafe_i) sync_q <= 2'b00;
      else                         sync_q <= {sync_q[0], 1'b1};
   end
   assign rst_n = sync_q[1];

   // Rectangle of the cell under the scanner and its overlap with the bullet.
   always_comb begin
      scan_idx = IW'(scan_row_q) * IW'(COLS_P) + IW'(scan_col_q);
      cell_l   = AW'(ox_q) + AW'(scan_col_q) * AW'(PITCH_X);
      cell_r   = cell_l + AW'(ENEMY_W_P - 1);
      cell_t   = AW'(oy_q) + AW'(scan_row_q) * AW'(PITCH_Y);
      cell_b   = cell_t + AW'(ENEMY_H_P - 1);
      overlap  = (AW'(bullet_left_i) <= cell_r) && (AW'(bullet_right_i) >= cell_l) &&
                 (AW'(bullet_top_i) <= cell_b) && (AW'(bullet_bot_i) >= cell_t);
      kill     = (state_q == MARCH) && bullet_valid_i && alive_q[scan_idx] && overlap &&
                 !lock_q;
      clear    = kill && (count_q == CW'(1));
   end

   // March timing, edge detection and landing test after a descent.
   always_comb begin
      tick    = (state_q == MARCH) && frame_i && (fcnt_q == FCW'(FRAMES_PER_STEP_P - 1));
      at_edge = dir_left_q ? (AW'(ox_q) < AW'(LEFT_BOUND_P + STEP_X_P))
                           : (AW'(ox_q) + AW'(FORM_W - 1 + STEP_X_P) > AW'(RIGHT_BOUND_P));
      oy_desc = oy_q + CORDW'(STEP_Y_P);
      land    = tick && at_edge && (AW'(oy_q) + AW'(STEP_Y_P + FORM_H) >= AW'(LAND_Y_P));
   end

   // Next-state: FSM, movement, scanner, kills and restart.
   always_comb begin
      state_d    = state_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      dir_left_d = dir_left_q;
      alive_d    = alive_q;
      fcnt_d     = fcnt_q;
      lock_d     = bullet_valid_i ? lock_q : 1'b0;
      scan_row_d = scan_row_q;
      scan_col_d = scan_col_q;
      hit_d      = 1'b0;
      hit_row_d  = hit_row_q;
      hit_col_d  = hit_col_q;
      count_d    = count_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = MARCH;
         end
         MARCH: begin
            if (frame_i) begin
               fcnt_d = tick ? '0 : fcnt_q + 1'b1;
            end
            if (tick) begin
               if (at_edge) begin
                  oy_d       = oy_desc;
                  dir_left_d = !dir_left_q;
               end else if (dir_left_q) begin
                  ox_d = ox_q - CORDW'(STEP_X_P);
               end else begin
                  ox_d = ox_q + CORDW'(STEP_X_P);
               end
            end
            if (scan_col_q == CLW'(COLS_P - 1)) begin
               scan_col_d = '0;
               scan_row_d = (scan_row_q == RLW'(ROWS_P - 1)) ? '0 : scan_row_q + 1'b1;
            end else begin
               scan_col_d = scan_col_q + 1'b1;
            end
            if (kill) begin
               alive_d[scan_idx] = 1'b0;
               hit_d             = 1'b1;
               hit_row_d         = scan_row_q;
               hit_col_d         = scan_col_q;
               count_d           = count_q - 1'b1;
               lock_d            = 1'b1;
            end
            // Landing wins over clearing in the same cycle.
            if (land)       state_d = LANDED;
            else if (clear) state_d = CLEARED;
         end
         LANDED, CLEARED: begin
            if (start_i) begin
               state_d    = MARCH;
               ox_d       = CORDW'(LEFT_START_P);
               oy_d       = CORDW'(TOP_START_P);
               dir_left_d = 1'b0;
               alive_d    = '1;
               fcnt_d     = '0;
               lock_d     = 1'b0;
               scan_row_d = '0;
               scan_col_d = '0;
               count_d    = CW'(NCELL);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-pixel test against every live cell; result registered for the colour mux.
   always_comb begin
      pixel_d = 1'b0;
      for (int r = 0; r < int'(ROWS_P); r++) begin
         for (int c = 0; c < int'(COLS_P); c++) begin
            if (alive_q[r * int'(COLS_P) + c] &&
                AW'(x_i) >= AW'(ox_q) + AW'(c * int'(PITCH_X)) &&
                AW'(x_i) <= AW'(ox_q) + AW'(c * int'(PITCH_X) + int'(ENEMY_W_P) - 1) &&
                AW'(y_i) >= AW'(oy_q) + AW'(r * int'(PITCH_Y)) &&
                AW'(y_i) <= AW'(oy_q) + AW'(r * int'(PITCH_Y) + int'(ENEMY_H_P) - 1)) begin
               pixel_d = 1'b1;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ox_q       <= CORDW'(LEFT_START_P);
         oy_q       <= CORDW'(TOP_START_P);
         dir_left_q <= 1'b0;
         alive_q    <= '1;
         fcnt_q     <= '0;
         lock_q     <= 1'b0;
         scan_row_q <= '0;
         scan_col_q <= '0;
         hit_q      <= 1'b0;
         hit_row_q  <= '0;
         hit_col_q  <= '0;
         count_q    <= CW'(NCELL);
         pixel_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         dir_left_q <= dir_left_d;
         alive_q    <= alive_d;
         fcnt_q     <= fcnt_d;
         lock_q     <= lock_d;
         scan_row_q <= scan_row_d;
         scan_col_q <= scan_col_d;
         hit_q      <= hit_d;
         hit_row_q  <= hit_row_d;
         hit_col_q  <= hit_col_d;
         count_q    <= count_d;
         pixel_q    <= pixel_d;
      end
   end

   assign hit_o         = hit_q;
   assign hit_row_o     = hit_row_q;
   assign hit_col_o     = hit_col_q;
   assign alive_count_o = count_q;
   assign pixel_on_o    = pixel_q;
   assign landed_o      = (state_q == LANDED);
   assign cleared_o     = (state_q == CLEARED);
   assign state_o       = state_q;

endmodule

// File: tb/tb_enemy_formation.sv
// Bench for enemy_formation: kill events go through a scoreboard queue checked by a
// monitor on every hit pulse; state, count and pixel probes are checked directly.
module tb_enemy_formation;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       frame = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic       bvalid = 1'b0;
   logic [9:0] bl = '0, br = '0, bt = '0, bb = '0;
   logic       hit;
   logic [1:0] hit_row;
   logic [2:0] hit_col;
   logic [4:0] alive_count;
   logic       pixel_on, landed, cleared;
   logic [2:0] state;

   typedef struct {int row; int col;} exp_t;
   exp_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int hit_cnt = 0;

   int m_ox, m_oy, m_landed, m_left, early;

   always #5 clk = ~clk;

   enemy_formation dut (
      .clk_i                  (clk),
      .reset_n_async_unsafe_i (rst_n),
      .start_i                (start),
      .frame_i                (frame),
      .x_i                    (x),
      .y_i                    (y),
      .bullet_valid_i         (bvalid),
      .bullet_left_i          (bl),
      .bullet_right_i         (br),
      .bullet_top_i           (bt),
      .bullet_bot_i           (bb),
      .hit_o                  (hit),
      .hit_row_o              (hit_row),
      .hit_col_o              (hit_col),
      .alive_count_o          (alive_count),
      .pixel_on_o             (pixel_on),
      .landed_o               (landed),
      .cleared_o              (cleared),
      .state_o                (state)
   );

   // Monitor: every kill pulse must match the oldest expected kill.
   always @(negedge clk) begin
      if (hit) begin
         vectors++;
         hit_cnt++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_hit actual=(%0d,%0d) required=none", hit_row, hit_col);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (int'(hit_row) != e.row || int'(hit_col) != e.col) begin
               miscompares++;
               $display("FAIL hit_cell actual=(%0d,%0d) required=(%0d,%0d)",
                        hit_row, hit_col, e.row, e.col);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      exp_q.delete();
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic frames(input int n);
      @(negedge clk);
      frame = 1'b1;
      repeat (n) @(negedge clk);
      frame = 1'b0;
   endtask

   task automatic probe(input string name, input int px, input int py, input int req);
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      @(negedge clk);
      chk(name, int'(pixel_on), req);
   endtask

   // Fire a bullet into cell (r,c) of a formation at (ox,oy), wait for the kill, drop it.
   task automatic shoot(input int r, input int c, input int ox, input int oy);
      int h0, n;
      exp_t e;
      @(negedge clk);
      bl = 10'(ox + 32 * c + 5);
      br = 10'(ox + 32 * c + 10);
      bt = 10'(oy + 24 * r + 5);
      bb = 10'(oy + 24 * r + 12);
      e.row = r;
      e.col = c;
      exp_q.push_back(e);
      bvalid = 1'b1;
      h0 = hit_cnt;
      n = 0;
      while (hit_cnt == h0 && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("shot_seen", int'(hit_cnt != h0), 1);
      bvalid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic model_tick();
      if (m_left == 0) begin
         if (m_ox + 249 > 639) begin m_oy += 8; m_left = 1; end
         else m_ox += 2;
      end else begin
         if (m_ox < 2) begin m_oy += 8; m_left = 0; end
         else m_ox -= 2;
      end
      if (m_oy + 64 >= 429) m_landed = 1;
   endtask

   initial begin
      int h0, guard;

      // Reset state and static drawing in IDLE.
      do_reset();
      chk("rst_state", int'(state), 0);
      chk("rst_alive", int'(alive_count), 24);
      chk("rst_landed", int'(landed), 0);
      chk("rst_cleared", int'(cleared), 0);
      chk("rst_hit", int'(hit), 0);
      probe("pix_cell00", 40, 40, 1);
      probe("pix_gap", 64, 40, 0);

      // One bullet, held valid: exactly one kill of cell (0,0).
      do_start();
      chk("march_state", int'(state), 1);
      shoot(0, 0, 40, 40);
      @(negedge clk);
      bvalid = 1'b1;
      h0 = hit_cnt;
      repeat (40) @(negedge clk);
      #1;
      chk("no_rekill", hit_cnt - h0, 0);
      bvalid = 1'b0;
      chk("alive_23", int'(alive_count), 23);
      probe("pix_dead", 40, 40, 0);
      probe("pix_cell01", 72, 40, 1);

      // Default march to the right edge, descent, reversal.
      do_reset();
      do_start();
      m_ox = 40; m_oy = 40; m_left = 0; m_landed = 0;
      frames(176 * 4);
      for (int i = 0; i < 176; i++) model_tick();
      probe("edge_on", 392, 40, 1);
      probe("edge_left", 391, 40, 0);
      frames(4);
      model_tick();
      probe("desc_on", 392, 48, 1);
      probe("desc_above", 392, 47, 0);
      probe("desc_left", 391, 48, 0);
      frames(4);
      model_tick();
      probe("rev_on", 390, 48, 1);
      probe("rev_left", 389, 48, 0);

      // Run to landing, tick by tick against the march model.
      early = 0;
      guard = 0;
      while (m_landed == 0 && guard < 12000) begin
         frames(4);
         model_tick();
         if (landed && m_landed == 0) early = 1;
         guard++;
      end
      chk("landed_not_early", early, 0);
      chk("landed", int'(landed), 1);
      chk("landed_state", int'(state), 2);
      frames(400);
      probe("frozen_on", m_ox, m_oy, 1);
      probe("frozen_above", m_ox, m_oy - 1, 0);
      probe("frozen_left", m_ox - 1, m_oy, 0);

      // Clear the whole formation, then restart.
      do_reset();
      do_start();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 8; c++)
            shoot(r, c, 40, 40);
      chk("cleared", int'(cleared), 1);
      chk("cleared_state", int'(state), 3);
      chk("cleared_alive", int'(alive_count), 0);
      do_start();
      chk("restart_state", int'(state), 1);
      chk("restart_alive", int'(alive_count), 24);
      probe("restart_pix", 40, 40, 1);
      probe("restart_pix_left", 39, 40, 0);

      // Asynchronous reset in the middle of a game.
      do_reset();
      do_start();
      shoot(0, 0, 40, 40);
      shoot(0, 1, 40, 40);
      shoot(1, 2, 40, 40);
      shoot(2, 3, 40, 40);
      shoot(2, 7, 40, 40);
      frames(8);
      chk("mid_alive", int'(alive_count), 19);
      probe("mid_pix", 44 + 128, 40, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_alive", int'(alive_count), 24);
      chk("arst_row", int'(hit_row), 0);
      chk("arst_col", int'(hit_col), 0);
      chk("arst_pix", int'(pixel_on), 0);
      chk("arst_hit", int'(hit), 0);
      chk("arst_flags", int'({landed, cleared}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("leftover_expected", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/enemy_formation.md
Name: enemy_formation

Overview:
- Parametrised enemy-grid controller. Successor to the single-enemy block: it manages a ROWS_P x COLS_P formation.
- Functions: alive bitmap, classic march (step sideways, descend at the screen edge, reverse direction), sequential bullet-hit scanning with one kill per shot, landed/cleared detection, and a registered per-pixel "enemy here" output for the colour mux.
- Runs on the pixel clock alongside player and dvi_controller, paced by the once-per-frame strobe.

Parameters:
- CORDW, 10, coordinate width
- ROWS_P, 3, formation rows
- COLS_P, 8, formation columns
- ENEMY_W_P, 24, enemy width in px
- ENEMY_H_P, 16, enemy height in px
- GAP_X_P, 8, horizontal gap between enemies
- GAP_Y_P, 8, vertical gap between enemies
- LEFT_START_P, 40, reset/restart origin x
- TOP_START_P, 40, reset/restart origin y
- STEP_X_P, 2, px per horizontal step
- STEP_Y_P, 8, px per descent
- FRAMES_PER_STEP_P, 4, frames between steps (>=1)
- LEFT_BOUND_P, 0, leftmost legal x
- RIGHT_BOUND_P, 639, rightmost legal x
- LAND_Y_P, 429, landing line (top of player)

Ports:
- clk_i, in, 1, pixel clock
- reset_n_async_unsafe_i, in, 1, asynchronous active-low reset
- start_i, in, 1, synchronised start/restart button
- frame_i, in, 1, one-cycle per-frame strobe
- x_i, in, CORDW, current pixel x
- y_i, in, CORDW, current pixel y
- bullet_valid_i, in, 1, player bullet in flight
- bullet_left_i, in, CORDW, bullet rectangle left, inclusive
- bullet_right_i, in, CORDW, bullet rectangle right, inclusive
- bullet_top_i, in, CORDW, bullet rectangle top, inclusive
- bullet_bot_i, in, CORDW, bullet rectangle bottom, inclusive
- hit_o, out, 1, one-cycle kill pulse
- hit_row_o, out, $clog2(ROWS_P), row of the last kill
- hit_col_o, out, $clog2(COLS_P), column of the last kill
- alive_count_o, out, $clog2(ROWS_P*COLS_P+1), enemies remaining
- pixel_on_o, out, 1, (x_i,y_i) lies on a live enemy; registered
- landed_o, out, 1, formation reached LAND_Y_P
- cleared_o, out, 1, all enemies dead
- state_o, out, 3, FSM state for debug LEDs

Behaviour:
- Derived constants: FORM_W = COLS_P*ENEMY_W_P + (COLS_P-1)*GAP_X_P; FORM_H likewise with rows. Cell (r,c) spans x in [ox + c*(ENEMY_W_P+GAP_X_P), +ENEMY_W_P-1] and y in [oy + r*(ENEMY_H_P+GAP_Y_P), +ENEMY_H_P-1]. All bounds are inclusive.
- FSM states: IDLE=0, MARCH=1, LANDED=2, CLEARED=3.
- Reset (async assert, sync release):
  - state IDLE; origin = (LEFT_START_P, TOP_START_P); direction right; alive bitmap all ones; frame counter 0; hit lock 0.
  - Outputs: hit_o=0, hit_row_o=0, hit_col_o=0, pixel_on_o=0, landed_o=0, cleared_o=0, alive_count_o=ROWS_P*COLS_P.
  - Reset mid-game has the same effect immediately.
- IDLE: formation is drawn at the start origin and does not move. start_i -> MARCH.
- MARCH stepping:
  - Frame counter increments on each frame_i and wraps at FRAMES_PER_STEP_P-1. The wrap frame is a step tick.
  - On a step tick moving right: if ox + FORM_W - 1 + STEP_X_P > RIGHT_BOUND_P, then oy += STEP_Y_P and the direction flips; ox is unchanged. Otherwise ox += STEP_X_P.
  - Moving left is symmetric: the edge condition is ox < LEFT_BOUND_P + STEP_X_P.
  - The edge check uses the full grid; it does not shrink to surviving columns.
- Landing: after any descent, if oy + FORM_H >= LAND_Y_P -> LANDED, landed_o=1. Movement stops; the formation is still drawn.
- Hit scanner:
  - In MARCH only, an index walks one cell per clock through all ROWS_P*COLS_P cells (row-major) and wraps.
  - A cell kills when all hold: bullet_valid_i, the cell is alive, the bullet and cell rectangles overlap (inclusive), and the hit lock is clear.
  - A kill clears the cell's alive bit, pulses hit_o for exactly one cycle, updates hit_row_o/hit_col_o (held until the next kill), decrements alive_count_o and sets the hit lock.
  - The hit lock clears when bullet_valid_i is low. This guarantees at most one kill per bullet.
  - Worst-case detection latency is ROWS_P*COLS_P cycles.
- Clearing: when alive_count_o reaches 0 -> CLEARED, cleared_o=1.
- A kill and a step tick in the same cycle both take effect. Landing takes priority over clearing when both occur in the same cycle.
- start_i in LANDED or CLEARED: the formation restores to its reset values, then enters MARCH on the same edge.
- start_i in MARCH is ignored.
- pixel_on_o: 1-cycle latency from x_i/y_i. It is 1 only when the pixel lies inside a live cell. Gaps and dead cells give 0. It is valid in every state.

Test Plan:
- Reset with defaults -> state_o=0, alive_count_o=24, all flags 0. Sample x_i=40,y_i=40 -> pixel_on_o=1 one cycle later. Sample x_i=64 (gap) -> pixel_on_o=0.
- start_i, then a bullet rectangle (45..50, 45..52) held valid -> within 24 cycles exactly one hit_o pulse with row=0, col=0; alive_count_o=23. Holding the bullet valid causes no further pulses. Sample (40,40) -> pixel_on_o=0.
- Default march with no hits: ox reaches 392 after 176 steps. The next tick (frame 708) leaves ox=392, sets oy=48 and reverses direction. The following tick gives ox=390.
- Run to landing: after the 41st descent oy=368 -> landed_o=1, state_o=2, and ox/oy stay frozen over further frames.
- Kill all 24 cells, dropping bullet_valid_i between shots -> cleared_o=1, state_o=3. start_i then restores alive_count_o=24 and origin (40,40), state_o=1.
- Assert reset_n_async_unsafe_i low mid-march with 5 kills done -> all outputs return to reset values within the same cycle.
